regfile32x32: RTL and testbench

Register file for the datapath: 32 registers of 32 bits, one synchronous write port, two asynchronous read ports. It sits directly upstream of the 32-to-1 read-port multiplexers and supplies their 32 register-value inputs. Register 0 is hardwired to zero. A same-cycle write-to-read bypass lets a value written in cycle N be visible on a read port in cycle N.

---
 rtl/regfile32x32_pkg.sv | 16 +
 rtl/mux32to1.sv | 21 ++
 rtl/reg32.sv | 31 +++
 rtl/regfile32x32.sv | 84 ++++++++
 tb/tb_regfile32x32.sv | 169 ++++++++++++++++
 5 files changed

// File: rtl/regfile32x32_pkg.sv
`default_nettype none
// ============================================================================
// Module      : regfile32x32_pkg
// Description : Shared constants for the datapath register file
// Revision    : 1.0 - initial release
// ============================================================================
package regfile32x32_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;
    localparam int NREGS  = 32;

    localparam logic [ADDR_W-1:0] ZERO_REG = 5'd0;

endpackage : regfile32x32_pkg
`default_nettype wire

// File: rtl/mux32to1.sv
`default_nettype none
// ============================================================================
// Module      : mux32to1
// Description : 32-input, 32-bit-wide read-port multiplexer
// Revision    : 1.0 - initial release
// ============================================================================
module mux32to1
    import regfile32x32_pkg::*;
(
    input  logic [NREGS-1:0][DATA_W-1:0] i_din,
    input  logic [ADDR_W-1:0]            i_sel,
    output logic [DATA_W-1:0]            o_dout
);

    // Plain indexed select
    always_comb begin
        o_dout = i_din[i_sel];
    end

endmodule : mux32to1
`default_nettype wire

// File: rtl/reg32.sv
`default_nettype none
// ============================================================================
// Module      : reg32
// Description : 32-bit register with synchronous active-high reset and load
// Revision    : 1.0 - initial release
// ============================================================================
module reg32
    import regfile32x32_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_d,
    output logic [DATA_W-1:0] o_q
);

    logic [DATA_W-1:0] r_q;

    // Clear on reset, otherwise capture the input when loaded
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q <= '0;
        end else if (i_load) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule : reg32
`default_nettype wire

// File: rtl/regfile32x32.sv
`default_nettype none
// ============================================================================
// Module      : regfile32x32
// Description : 32x32 register file, one synchronous write port, two
//               combinational read ports with same-cycle write bypass.
//               Register 0 has no storage and always reads zero.
// Revision    : 1.0 - initial release
// ============================================================================
module regfile32x32
    import regfile32x32_pkg::*;
#(
    parameter int DATA_W = regfile32x32_pkg::DATA_W,
    parameter int ADDR_W = regfile32x32_pkg::ADDR_W,
    parameter int NREGS  = regfile32x32_pkg::NREGS
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr0,
    output logic [DATA_W-1:0] rdata0,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1
);

    // A write is only effective when reset is low; reset wins over a
    // coincident write and also suppresses the bypass.
    logic                            w_wr_active;
    logic [NREGS-1:1]                w_wdec;
    logic [NREGS-1:0][DATA_W-1:0]    w_regs;
    logic [DATA_W-1:0]               w_mux0;
    logic [DATA_W-1:0]               w_mux1;
    logic                            w_byp0;
    logic                            w_byp1;

    assign w_wr_active = we & ~reset;

    // One-hot write decode; index 0 is never decoded so r0 cannot be written
    always_comb begin
        w_wdec = '0;
        for (int i = 1; i < NREGS; i++) begin
            w_wdec[i] = w_wr_active & (waddr == ADDR_W'(i));
        end
    end

    assign w_regs[0] = '0;

    generate
        for (genvar g = 1; g < NREGS; g++) begin : g_reg
            reg32 u_reg (
                .clk    (clk),
                .rst    (reset),
                .i_load (w_wdec[g]),
                .i_d    (wdata),
                .o_q    (w_regs[g])
            );
        end
    endgenerate

    mux32to1 u_mux0 (
        .i_din  (w_regs),
        .i_sel  (raddr0),
        .o_dout (w_mux0)
    );

    mux32to1 u_mux1 (
        .i_din  (w_regs),
        .i_sel  (raddr1),
        .o_dout (w_mux1)
    );

    // Bypass only for non-zero addresses so a discarded r0 write never leaks
    assign w_byp0 = w_wr_active & (waddr == raddr0) & (raddr0 != ZERO_REG);
    assign w_byp1 = w_wr_active & (waddr == raddr1) & (raddr1 != ZERO_REG);

    // Post-mux bypass select for each read port
    always_comb begin
        rdata0 = w_byp0 ? wdata : w_mux0;
        rdata1 = w_byp1 ? wdata : w_mux1;
    end

endmodule : regfile32x32
`default_nettype wire

// File: tb/tb_regfile32x32.sv
`default_nettype none
// ============================================================================
// Module      : tb_regfile32x32
// Description : Scoreboard bench for regfile32x32 with directed vectors
// Revision    : 1.0 - initial release
// ============================================================================
module tb_regfile32x32;

    logic        clk;
    logic        reset;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr0;
    logic [31:0] rdata0;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;

    // Marks a cycle whose outputs have an expected entry in the scoreboard
    logic        chk_valid;

    logic [31:0] exp0_q[$];
    logic [31:0] exp1_q[$];
    string       name_q[$];

    int checks;
    int failures;

    regfile32x32 dut (
        .clk    (clk),
        .reset  (reset),
        .we     (we),
        .waddr  (waddr),
        .wdata  (wdata),
        .raddr0 (raddr0),
        .rdata0 (rdata0),
        .raddr1 (raddr1),
        .rdata1 (rdata1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs just after the rising edge; optionally queue
    // the expected read data for the monitor
    task automatic step(input logic rst_i, input logic we_i, input logic [4:0] wa,
                        input logic [31:0] wd, input logic [4:0] ra0,
                        input logic [4:0] ra1, input logic chk,
                        input logic [31:0] e0, input logic [31:0] e1,
                        input string nm);
        @(posedge clk);
        #1;
        reset  = rst_i;
        we     = we_i;
        waddr  = wa;
        wdata  = wd;
        raddr0 = ra0;
        raddr1 = ra1;
        if (chk) begin
            exp0_q.push_back(e0);
            exp1_q.push_back(e1);
            name_q.push_back(nm);
        end
        chk_valid = chk;
    endtask

    // Monitor: compare both read ports at the falling edge of checked cycles
    always @(negedge clk) begin
        if (chk_valid) begin
            if (exp0_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL scoreboard_empty: output present with no expected entry");
            end else begin
                automatic logic [31:0] e0 = exp0_q.pop_front();
                automatic logic [31:0] e1 = exp1_q.pop_front();
                automatic string       nm = name_q.pop_front();
                checks++;
                if (rdata0 !== e0) begin
                    failures++;
                    $display("FAIL %s rdata0: got %08h expected %08h", nm, rdata0, e0);
                end
                checks++;
                if (rdata1 !== e1) begin
                    failures++;
                    $display("FAIL %s rdata1: got %08h expected %08h", nm, rdata1, e1);
                end
            end
        end
    end

    initial begin
        checks    = 0;
        failures  = 0;
        chk_valid = 1'b0;
        reset     = 1'b1;
        we        = 1'b0;
        waddr     = 5'd0;
        wdata     = 32'h0;
        raddr0    = 5'd0;
        raddr1    = 5'd0;

        // Reset for one edge, then sweep every address on both ports
        step(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, "");
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1,
                 32'h0, 32'h0, "reset_sweep");
        end

        // Write r1..r31 on consecutive cycles; bypass shows the new value
        for (int i = 1; i < 32; i++) begin
            step(1'b0, 1'b1, 5'(i), 32'hA5A5_0000 + i, 5'(i), 5'(i), 1'b1,
                 32'hA5A5_0000 + i, 32'hA5A5_0000 + i, "write_bypass");
        end

        // Read everything back from storage on both ports
        for (int i = 0; i < 32; i++) begin
            step(1'b0, 1'b0, 5'd0, 32'h0, 5'(i), 5'(31 - i), 1'b1,
                 (i == 0) ? 32'h0 : 32'hA5A5_0000 + i,
                 (i == 31) ? 32'h0 : 32'hA5A5_0000 + (31 - i), "readback");
        end

        // Zero register: write to r0 is discarded, both during and after
        step(1'b0, 1'b1, 5'd0, 32'hFFFF_FFFF, 5'd0, 5'd1, 1'b1,
             32'h0, 32'hA5A5_0001, "zero_write_cycle");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd1, 1'b1,
             32'h0, 32'hA5A5_0001, "zero_after");

        // Bypass: r5 = 1111_1111, then overwrite with 2222_2222
        step(1'b0, 1'b1, 5'd5, 32'h1111_1111, 5'd5, 5'd6, 1'b1,
             32'h1111_1111, 32'hA5A5_0006, "r5_load");
        step(1'b0, 1'b1, 5'd5, 32'h2222_2222, 5'd5, 5'd6, 1'b1,
             32'h2222_2222, 32'hA5A5_0006, "bypass_same_cycle");
        step(1'b0, 1'b0, 5'd5, 32'h2222_2222, 5'd5, 5'd6, 1'b1,
             32'h2222_2222, 32'hA5A5_0006, "bypass_next_cycle");

        // Reset vs write: bypass suppressed during reset, everything cleared after
        step(1'b0, 1'b1, 5'd7, 32'hDEAD_BEEF, 5'd4, 5'd5, 1'b1,
             32'hA5A5_0004, 32'h2222_2222, "r7_load");
        step(1'b1, 1'b1, 5'd7, 32'h1234_5678, 5'd7, 5'd5, 1'b1,
             32'hDEAD_BEEF, 32'h2222_2222, "reset_vs_write");
        step(1'b0, 1'b0, 5'd7, 32'h1234_5678, 5'd7, 5'd5, 1'b1,
             32'h0, 32'h0, "after_reset");

        // Back-to-back writes to r3: last one wins
        step(1'b0, 1'b1, 5'd3, 32'h0000_0001, 5'd3, 5'd4, 1'b1,
             32'h0000_0001, 32'h0, "b2b_first");
        step(1'b0, 1'b1, 5'd3, 32'h0000_0002, 5'd3, 5'd7, 1'b1,
             32'h0000_0002, 32'h0, "b2b_second");
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd3, 1'b1,
             32'h0000_0002, 32'h0000_0002, "b2b_result");

        // Stop issuing and let the monitor drain, with a bounded wait
        step(1'b0, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0, 1'b0, 32'h0, 32'h0, "");
        for (int k = 0; k < 4 && exp0_q.size() != 0; k++) begin
            @(negedge clk);
        end
        if (exp0_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp0_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile32x32
`default_nettype wire
